// File: rtl/jk_sequencer.sv
// Automatic J/K truth-table sequencer for a pulse-triggered JK flip-flop under test:
// drives J, K and a slow clock pulse, samples Q after each falling edge, reports on LEDs.
module jk_sequencer #(
    parameter int PHASE_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       sw0_RST,
    input  logic       sw1_MODE,
    input  logic       btn_STEP,
    input  logic       dut_Q,
    output logic       dut_CLK,
    output logic       dut_J,
    output logic       dut_K,
    output logic [2:0] led_STEP,
    output logic       led_PASS,
    output logic       led_FAIL,
    output logic       led_BUSY
);

    localparam int CNT_W = $clog2(PHASE_CYCLES);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);

    // Vector table: {J, K} applied at each step and the Q expected afterwards.
    localparam logic [1:0] ROM_JK [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10};
    localparam logic       ROM_Q  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_smp_q, q_smp_d;
    logic             j_q, j_d, k_q, k_d;
    logic             clk_out_q, clk_out_d;
    logic             pass_q, pass_d, fail_q, fail_d, busy_q, busy_d;
    logic             btn_prev_q, btn_prev_d;
    logic             step_evt_q, step_evt_d;

    logic [1:0] mode_sync_q, mode_sync_d;
    logic [1:0] btn_sync_q, btn_sync_d;
    logic [1:0] q_sync_q, q_sync_d;

    logic mode_s, btn_s, q_s, cnt_done;

    assign mode_s   = mode_sync_q[1];
    assign btn_s    = btn_sync_q[1];
    assign q_s      = q_sync_q[1];
    assign cnt_done = (cnt_q == '0);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned and infers a latch.
        mode_sync_d = {mode_sync_q[0], sw1_MODE};
        btn_sync_d  = {btn_sync_q[0], btn_STEP};
        q_sync_d    = {q_sync_q[0], dut_Q};
        btn_prev_d  = btn_s;
        step_evt_d  = btn_s & ~btn_prev_q;

        state_d = state_q;
        step_d  = step_q;
        q_smp_d = q_smp_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE:  if (mode_s || step_evt_q) state_d = S_SETUP;
            S_SETUP: if (cnt_done) state_d = S_HIGH;
            S_HIGH:  if (cnt_done) state_d = S_LOW;
            S_LOW: begin
                if (cnt_done) begin
                    q_smp_d = q_s;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (q_smp_q != ROM_Q[step_q]) begin
                    state_d = S_FAIL;
                end else if (step_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = mode_s ? S_SETUP : S_IDLE;
                end
            end
            S_DONE, S_FAIL: begin
                if (step_evt_q) begin
                    state_d = S_IDLE;
                    step_d  = 3'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Each timed phase reloads on entry; CHECK and the waiting states leave it parked at zero.
        if (state_d != state_q && (state_d == S_SETUP || state_d == S_HIGH || state_d == S_LOW))
            cnt_d = PHASE_LAST;
        else if (!cnt_done)
            cnt_d = cnt_q - CNT_W'(1);

        // J/K move only on SETUP entry so they are stable before and throughout the high phase.
        if (state_d == S_SETUP && state_q != S_SETUP)
            {j_d, k_d} = ROM_JK[step_d];

        clk_out_d = (state_d == S_HIGH);
        pass_d    = (state_d == S_DONE);
        fail_d    = (state_d == S_FAIL);
        busy_d    = (state_d == S_SETUP) || (state_d == S_HIGH) ||
                    (state_d == S_LOW)   || (state_d == S_CHECK);
    end

    // NOTE: synchronizer flops carry no reset; they flush within two cycles, and a mode switch held through reset acts on the first edge after it.
    always_ff @(posedge clk) begin
        mode_sync_q <= mode_sync_d;
        btn_sync_q  <= btn_sync_d;
        q_sync_q    <= q_sync_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sw0_RST) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            cnt_q      <= '0;
            q_smp_q    <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            clk_out_q  <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            btn_prev_q <= 1'b0;
            step_evt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            q_smp_q    <= q_smp_d;
            j_q        <= j_d;
            k_q        <= k_d;
            clk_out_q  <= clk_out_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            btn_prev_q <= btn_prev_d;
            step_evt_q <= step_evt_d;
        end
    end

    assign dut_CLK  = clk_out_q;
    assign dut_J    = j_q;
    assign dut_K    = k_q;
    assign led_STEP = step_q;
    assign led_PASS = pass_q;
    assign led_FAIL = fail_q;
    assign led_BUSY = busy_q;

endmodule

// File: tb/tb_jk_sequencer.sv
// Scoreboard bench for jk_sequencer: a run-level reference model predicts every clock
// pulse and the final verdict; a monitor compares them as the DUT produces them.
module tb_jk_sequencer;

    localparam int P        = 4;
    localparam int STEP_CYC = 3 * P + 1;
    localparam int F_IDEAL  = 0;
    localparam int F_STUCK0 = 1;
    localparam int F_STUCK1 = 2;
    localparam int F_INV    = 3;

    localparam logic [1:0] JK_TBL  [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10};
    localparam logic       EXP_TBL [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       sw0_RST, sw1_MODE, btn_STEP, dut_Q;
    logic       dut_CLK, dut_J, dut_K, led_PASS, led_FAIL, led_BUSY;
    logic [2:0] led_STEP;

    jk_sequencer #(.PHASE_CYCLES(P)) dut (
        .clk      (clk),
        .sw0_RST  (sw0_RST),
        .sw1_MODE (sw1_MODE),
        .btn_STEP (btn_STEP),
        .dut_Q    (dut_Q),
        .dut_CLK  (dut_CLK),
        .dut_J    (dut_J),
        .dut_K    (dut_K),
        .led_STEP (led_STEP),
        .led_PASS (led_PASS),
        .led_FAIL (led_FAIL),
        .led_BUSY (led_BUSY)
    );

    always #5 clk = ~clk;

    // Flip-flop under test: master-slave JK, output changes on the falling clock edge.
    logic ff_q  = 1'b0;
    int   fault = F_IDEAL;
    always @(negedge dut_CLK) begin
        case ({dut_J, dut_K})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end
    assign dut_Q = (fault == F_IDEAL)  ? ff_q :
                   (fault == F_STUCK0) ? 1'b0 :
                   (fault == F_STUCK1) ? 1'b1 : ~ff_q;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct { int step; int j; int k; } pulse_t;
    typedef struct { bit pass; int step; int cyc; } term_t;
    pulse_t pulse_q[$];
    term_t  term_q[$];

    // Reference model: plays the 8-step table against the chosen flip-flop behaviour.
    task automatic push_run(input int flt, input bit timed);
        int     q = 0;
        int     obs, j, k;
        pulse_t p;
        term_t  t;
        for (int i = 0; i < 8; i++) begin
            j = int'(JK_TBL[i][1]);
            k = int'(JK_TBL[i][0]);
            p.step = i; p.j = j; p.k = k;
            pulse_q.push_back(p);
            if (j == 1 && k == 1) q = 1 - q;
            else if (j == 1)      q = 1;
            else if (k == 1)      q = 0;
            case (flt)
                F_STUCK0: obs = 0;
                F_STUCK1: obs = 1;
                F_INV:    obs = 1 - q;
                default:  obs = q;
            endcase
            if (obs != int'(EXP_TBL[i]) || i == 7) begin
                t.pass = (obs == int'(EXP_TBL[i]));
                t.step = i;
                t.cyc  = timed ? 1 + (i + 1) * STEP_CYC : -1;
                term_q.push_back(t);
                break;
            end
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= sw0_RST ? 0 : cyc + 1;

    bit         in_pulse = 1'b0, jk_stable = 1'b0, pass_prev = 1'b0, fail_prev = 1'b0;
    int         width = 0, pulse_cnt = 0;
    logic [2:0] p_step;
    logic       p_j, p_k;

    task automatic term_event(input bit is_pass);
        term_t te;
        check("terminal expected", int'(term_q.size() > 0), 1);
        if (term_q.size() > 0) begin
            te = term_q.pop_front();
            check("terminal is pass", int'(is_pass), int'(te.pass));
            check("terminal step", int'(led_STEP), te.step);
            if (te.cyc >= 0) check("terminal cycle", cyc, te.cyc);
            check("pass and fail together", int'(led_PASS & led_FAIL), 0);
        end
    endtask

    // Monitor: every completed dut_CLK pulse and every PASS/FAIL assertion is matched against the scoreboard.
    always @(negedge clk) begin
        pulse_t pe;
        if (sw0_RST) begin
            in_pulse = 1'b0;
        end else begin
            if (dut_CLK) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1; width = 0; jk_stable = 1'b1;
                    p_step = led_STEP; p_j = dut_J; p_k = dut_K;
                end
                width++;
                if (dut_J !== p_j || dut_K !== p_k) jk_stable = 1'b0;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                pulse_cnt++;
                check("pulse expected", int'(pulse_q.size() > 0), 1);
                if (pulse_q.size() > 0) begin
                    pe = pulse_q.pop_front();
                    check("pulse step", int'(p_step), pe.step);
                    check("pulse J", int'(p_j), pe.j);
                    check("pulse K", int'(p_k), pe.k);
                    check("pulse width", width, P);
                    check("J/K stable while high", int'(jk_stable), 1);
                end
            end
            if (led_PASS && !pass_prev) term_event(1'b1);
            if (led_FAIL && !fail_prev) term_event(1'b0);
        end
        pass_prev = led_PASS;
        fail_prev = led_FAIL;
    end

    task automatic do_reset(input logic mode);
        sw0_RST = 1'b1; sw1_MODE = mode; btn_STEP = 1'b0;
        repeat (3) @(negedge clk);
        pulse_q.delete();
        term_q.delete();
        sw0_RST = 1'b0;
    endtask

    task automatic press();
        btn_STEP = 1'b1;
        repeat ($urandom_range(4, 8)) @(negedge clk);
        btn_STEP = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((pulse_q.size() != 0 || term_q.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        check({name, " scoreboard drained"}, pulse_q.size() + term_q.size(), 0);
    endtask

    task automatic wait_step_high(input int s, input string name);
        int n = 0;
        while (!(int'(led_STEP) == s && dut_CLK) && n < 500) begin
            @(negedge clk); n++;
        end
        check({name, " reached high phase"}, int'(n < 500), 1);
    endtask

    task automatic wait_clk_low(input string name);
        int n = 0;
        while (dut_CLK && n < 50) begin @(negedge clk); n++; end
        check({name, " clock fell"}, int'(n < 50), 1);
    endtask

    task automatic wait_busy_low(input string name);
        int n = 0;
        while (led_BUSY && n < 100) begin @(negedge clk); n++; end
        check({name, " step finished"}, int'(n < 100), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        sw0_RST = 1'b1; sw1_MODE = 1'b0; btn_STEP = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dut_CLK", int'(dut_CLK), 0);
        check("reset dut_J", int'(dut_J), 0);
        check("reset dut_K", int'(dut_K), 0);
        check("reset led_STEP", int'(led_STEP), 0);
        check("reset led_PASS", int'(led_PASS), 0);
        check("reset led_FAIL", int'(led_FAIL), 0);
        check("reset led_BUSY", int'(led_BUSY), 0);

        // Automatic run with an ideal flip-flop.
        fault = F_IDEAL;
        do_reset(1'b1);
        base = pulse_cnt;
        push_run(F_IDEAL, 1'b1);
        wait_drain(300, "auto ideal");
        repeat (10) @(negedge clk);
        check("auto ideal pulse count", pulse_cnt - base, 8);
        check("auto ideal led_PASS held", int'(led_PASS), 1);
        check("auto ideal led_FAIL", int'(led_FAIL), 0);
        check("auto ideal dut_CLK idle", int'(dut_CLK), 0);

        // Q stuck low: fails at step 2 and freezes the outputs.
        fault = F_STUCK0;
        do_reset(1'b1);
        base = pulse_cnt;
        push_run(F_STUCK0, 1'b1);
        wait_drain(300, "stuck0");
        repeat (30) @(negedge clk);
        check("stuck0 pulse count", pulse_cnt - base, 3);
        check("stuck0 dut_CLK", int'(dut_CLK), 0);
        check("stuck0 dut_J held", int'(dut_J), 1);
        check("stuck0 dut_K held", int'(dut_K), 0);
        check("stuck0 led_STEP", int'(led_STEP), 2);
        check("stuck0 led_FAIL", int'(led_FAIL), 1);

        // Inverted Q: fails at step 0, then the button clears it and a new run passes.
        fault = F_INV;
        do_reset(1'b1);
        push_run(F_INV, 1'b1);
        wait_drain(100, "inverted");
        sw1_MODE = 1'b0;
        press();
        check("restart led_STEP", int'(led_STEP), 0);
        check("restart led_FAIL", int'(led_FAIL), 0);
        check("restart led_BUSY", int'(led_BUSY), 0);
        fault = F_IDEAL;
        push_run(F_IDEAL, 1'b0);
        sw1_MODE = 1'b1;
        wait_drain(300, "restart run");
        check("restart run led_PASS", int'(led_PASS), 1);

        // Manual single-step.
        do_reset(1'b0);
        base = pulse_cnt;
        repeat (200) @(negedge clk);
        check("manual idle pulse count", pulse_cnt - base, 0);
        check("manual idle in pulse", int'(in_pulse), 0);
        check("manual idle led_BUSY", int'(led_BUSY), 0);
        check("manual idle led_STEP", int'(led_STEP), 0);
        push_run(F_IDEAL, 1'b0);
        for (int i = 0; i < 8; i++) begin
            base = pulse_cnt;
            press();
            wait_busy_low("manual");
            repeat ($urandom_range(5, 15)) @(negedge clk);
            check("manual one pulse per press", pulse_cnt - base, 1);
            check("manual led_STEP", int'(led_STEP), (i < 7) ? i + 1 : 7);
            check("manual led_PASS", int'(led_PASS), (i == 7) ? 1 : 0);
        end
        wait_drain(10, "manual");

        // Reset during the high phase of step 4.
        do_reset(1'b1);
        push_run(F_IDEAL, 1'b1);
        wait_step_high(4, "reset mid-step");
        sw0_RST = 1'b1;
        @(negedge clk);
        check("mid reset dut_CLK", int'(dut_CLK), 0);
        check("mid reset led_STEP", int'(led_STEP), 0);
        check("mid reset led_BUSY", int'(led_BUSY), 0);
        check("mid reset dut_J", int'(dut_J), 0);
        check("mid reset dut_K", int'(dut_K), 0);
        do_reset(1'b1);
        base = pulse_cnt;
        push_run(F_IDEAL, 1'b1);
        wait_drain(300, "after mid reset");
        check("after mid reset pulse count", pulse_cnt - base, 8);

        // Mode dropped to manual during the low phase of step 3.
        do_reset(1'b1);
        push_run(F_IDEAL, 1'b0);
        wait_step_high(3, "mode toggle");
        wait_clk_low("mode toggle");
        sw1_MODE = 1'b0;
        repeat (40) @(negedge clk);
        check("mode toggle led_STEP", int'(led_STEP), 4);
        check("mode toggle led_BUSY", int'(led_BUSY), 0);
        check("mode toggle pending pulses", pulse_q.size(), 4);
        press();
        wait_busy_low("mode toggle press");
        repeat (5) @(negedge clk);
        check("mode toggle after press led_STEP", int'(led_STEP), 5);
        sw1_MODE = 1'b1;
        wait_drain(300, "mode toggle resume");
        check("mode toggle resume led_PASS", int'(led_PASS), 1);

        // Randomized flip-flop behaviours in automatic mode.
        for (int r = 0; r < 6; r++) begin
            fault = int'($urandom_range(0, 3));
            do_reset(1'b1);
            push_run(fault, 1'b1);
            wait_drain(300, "random run");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
